// File: rtl/ram_ready.sv
// rtl/ram_ready.sv - SDRAM slot timing and bus-cycle handshake companion
//
// Runs the substate counter SS and the 4-slot command cycle RS in lockstep
// with the SDRAM sequencer. It captures one RAM/ROM access per CPU strobe,
// pulses RDLE at CAS latency for reads, and raises RAMRDY when the access
// slot is served. ERR latches if a selected access goes unserved too long.
//
// Ports:
//   CLK    in   fast clock
//   RST    in   synchronous active-high reset
//   nAS    in   CPU address strobe, active-low
//   nWE    in   CPU write, active-low
//   BACT   in   bus cycle active qualifier for capture
//   RAMCS  in   RAM select
//   ROMCS  in   ROM select
//   SS     out  2-bit free-running substate counter
//   RS     out  2-bit slot state
//   RAMRDY out  access complete, held while nAS=0
//   RDLE   out  one-CLK read-data latch enable
//   ERR    out  sticky stall flag

module ram_ready #(
  parameter int CL   = 2,
  parameter int TOUT = 63
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       nAS,
  input  logic       nWE,
  input  logic       BACT,
  input  logic       RAMCS,
  input  logic       ROMCS,
  output logic [1:0] SS,
  output logic [1:0] RS,
  output logic       RAMRDY,
  output logic       RDLE,
  output logic       ERR
);

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_t;

  localparam logic [1:0] CL_SS  = 2'(CL - 1);
  localparam logic [5:0] TOUT_V = 6'(TOUT);

  slot_t       rs_q, rs_nxt;
  logic [1:0]  ss_nxt;
  logic        pend, pend_nxt;
  logic        wr, wr_nxt;
  logic        done, done_nxt;
  logic        rdy_nxt, rdle_nxt, err_nxt;
  logic [5:0]  tcnt, tcnt_nxt;
  logic        selected, capture, serve, slot_end;

  assign RS = rs_q;

  always_comb begin
    ss_nxt   = SS + 2'd1;
    rs_nxt   = rs_q;
    pend_nxt = pend;
    wr_nxt   = wr;
    done_nxt = done;
    rdy_nxt  = RAMRDY;
    tcnt_nxt = tcnt;

    selected = RAMCS | ROMCS;
    slot_end = (SS == 2'd3);
    capture  = (rs_q == SLOT1) && (SS == 2'd1) && !nAS && BACT && selected && !done;
    serve    = (rs_q == SLOT2) && slot_end && pend;

    if (slot_end) begin
      case (rs_q)
        SLOT0:   rs_nxt = SLOT1;
        // An already-served strobe skips the access slot (refresh slot).
        SLOT1:   if (!nAS) rs_nxt = done ? SLOT3 : SLOT2;
        SLOT2:   rs_nxt = SLOT3;
        SLOT3:   rs_nxt = SLOT0;
        default: rs_nxt = SLOT0;
      endcase
    end

    // Release wins over serve: a strobe that ends on the serve edge is dropped.
    if (nAS) begin
      rdy_nxt  = 1'b0;
      pend_nxt = 1'b0;
      if (slot_end) done_nxt = 1'b0;
    end else begin
      if (capture) begin
        pend_nxt = 1'b1;
        wr_nxt   = ~nWE & RAMCS;  // ROM writes complete as reads
      end
      if (serve) begin
        pend_nxt = 1'b0;
        done_nxt = 1'b1;
        rdy_nxt  = 1'b1;
      end
    end

    // RDLE is registered, so it is decoded from the state the next cycle will hold.
    rdle_nxt = (rs_nxt == SLOT2) && (ss_nxt == CL_SS) && pend_nxt && !wr_nxt;

    if (nAS || done) begin
      tcnt_nxt = 6'd0;
    end else if ((rs_q == SLOT3) && slot_end && selected && (tcnt != 6'h3f)) begin
      tcnt_nxt = tcnt + 6'd1;
    end

    err_nxt = ERR | (tcnt_nxt >= TOUT_V);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      SS     <= 2'd0;
      rs_q   <= SLOT0;
      RAMRDY <= 1'b0;
      RDLE   <= 1'b0;
      ERR    <= 1'b0;
      pend   <= 1'b0;
      wr     <= 1'b0;
      done   <= 1'b0;
      tcnt   <= 6'd0;
    end else begin
      SS     <= ss_nxt;
      rs_q   <= rs_nxt;
      RAMRDY <= rdy_nxt;
      RDLE   <= rdle_nxt;
      ERR    <= err_nxt;
      pend   <= pend_nxt;
      wr     <= wr_nxt;
      done   <= done_nxt;
      tcnt   <= tcnt_nxt;
    end
  end

endmodule
